// File: rtl/sig_trace_recorder.sv
// sig_trace_recorder: captures {cycle, probe} records into a FIFO and streams them
// to the host as fixed-width beats over valid/ready, counting any records it drops.
module sig_trace_recorder #(
    parameter int PROBE_W = 64,
    parameter int CYCLE_W = 48,
    parameter int BEAT_W  = 32,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               arm,
    input  logic               sample,
    input  logic [PROBE_W-1:0] probe,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BEAT_W-1:0]  out_data,
    output logic               out_last,
    output logic               overflow,
    output logic [CNT_W-1:0]   drop_count,
    output logic [CYCLE_W-1:0] cycle
);
    localparam int REC_W  = PROBE_W + CYCLE_W;
    localparam int NBEATS = (REC_W + BEAT_W - 1) / BEAT_W;
    localparam int SR_W   = NBEATS * BEAT_W;
    localparam int AW     = $clog2(DEPTH);
    localparam int BW     = NBEATS > 1 ? $clog2(NBEATS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state, state_n;
    logic [REC_W-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic [SR_W-1:0]  sr;
    logic [BW-1:0]    beat_idx;
    logic             empty, full, last, hs, pop, push, drop;

    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    always_ff @(posedge clock) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // A pop on the final handshake frees a slot, so a full FIFO can still accept that cycle.
    always_comb begin
        out_valid = state == SEND;
        last      = beat_idx == BW'(NBEATS - 1);
        out_last  = out_valid && last;
        out_data  = out_valid ? sr[BEAT_W-1:0] : '0;
        hs        = out_valid && out_ready;
        pop       = !empty && (state == IDLE || (hs && last));
        push      = arm && sample && (!full || pop);
        drop      = arm && sample && full && !pop;
        state_n   = pop ? SEND : (hs && last) ? IDLE : state;
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wptr[AW-1:0]] <= {cycle, probe};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr       <= '0;
            rptr       <= '0;
            sr         <= '0;
            beat_idx   <= '0;
            cycle      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            cycle <= cycle + CYCLE_W'(1);
            if (push)
                wptr <= wptr + (AW+1)'(1);
            if (pop)
                rptr <= rptr + (AW+1)'(1);
            if (pop) begin
                sr       <= SR_W'(mem[rptr[AW-1:0]]);
                beat_idx <= '0;
            end else if (hs) begin
                sr       <= sr >> BEAT_W;
                beat_idx <= beat_idx + BW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (~&drop_count)
                    drop_count <= drop_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_sig_trace_recorder.sv
// tb_sig_trace_recorder: directed stimulus with a queue-based record model checked every cycle,
// plus literal expectations for the single-capture, overflow, reset and cycle-wrap scenarios.
module tb_sig_trace_recorder;
    localparam int NB    = 4;
    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        arm = 1'b0, sample = 1'b0, out_ready = 1'b1;
    logic [63:0] probe = '0;
    logic        out_valid, out_last, overflow;
    logic [31:0] out_data, drop_count;
    logic [47:0] cycle;

    logic        w_arm = 1'b0, w_sample = 1'b0;
    logic [63:0] w_probe = '0;
    logic        w_valid, w_last, w_ovf;
    logic [31:0] w_data, w_drops;
    logic [7:0]  w_cycle;

    always #5 clock = ~clock;

    sig_trace_recorder dut (
        .clock(clock), .reset(reset), .arm(arm), .sample(sample), .probe(probe),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .overflow(overflow), .drop_count(drop_count), .cycle(cycle)
    );

    sig_trace_recorder #(.CYCLE_W(8)) u_wrap (
        .clock(clock), .reset(reset), .arm(w_arm), .sample(w_sample), .probe(w_probe),
        .out_valid(w_valid), .out_ready(1'b1), .out_data(w_data), .out_last(w_last),
        .overflow(w_ovf), .drop_count(w_drops), .cycle(w_cycle)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        longint      stamp;
        logic [63:0] pr;
    } rec_t;

    rec_t        q[$];
    int          bidx = 0;
    longint      now = 0;
    longint      m_drops = 0;
    bit          m_ovf = 0, started = 0;
    longint      first_valid = -1;
    logic [31:0] seen[$];
    bit          seen_last[$];
    longint      seen_t[$];
    logic [31:0] w_seen[$];
    bit          w_seen_last[$];
    logic [31:0] e1 [4] = '{32'h55667788, 32'h11223344, 32'h00000005, 32'h00000000};

    function automatic logic [31:0] beat_of(input rec_t r, input int i);
        logic [127:0] flat;
        flat = {16'b0, r.stamp[47:0], r.pr};
        return flat[i*32 +: 32];
    endfunction

    // Model: a record captured in cycle N is shown from N+2 at the earliest, in capture order;
    // at most DEPTH+1 records are in flight unless the head completes in the same cycle.
    always @(negedge clock) begin
        if (!reset) begin
            q.delete();
            bidx = 0;
            now = 0;
            m_drops = 0;
            m_ovf = 0;
            started = 1;
        end else if (started) begin
            bit mv, hs, done;
            mv = q.size() > 0 ? now >= q[0].stamp + 2 : 1'b0;
            chk("cycle", 64'(cycle), 64'(now[47:0]));
            chk("drop_count", 64'(drop_count), 64'(m_drops));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("out_valid", 64'(out_valid), 64'(mv));
            if (out_valid && first_valid < 0)
                first_valid = now;
            if (mv) begin
                chk("out_data", 64'(out_data), 64'(beat_of(q[0], bidx)));
                chk("out_last", 64'(out_last), 64'(bidx == NB - 1));
            end
            hs = mv && out_ready;
            done = hs && bidx == NB - 1;
            if (hs) begin
                seen.push_back(out_data);
                seen_last.push_back(out_last);
                seen_t.push_back(now);
            end
            if (arm && sample) begin
                if (q.size() < DEPTH + 1 || done)
                    q.push_back('{now, probe});
                else begin
                    m_ovf = 1;
                    m_drops++;
                end
            end
            if (done) begin
                void'(q.pop_front());
                bidx = 0;
            end else if (hs)
                bidx++;
            now++;
        end
    end

    always @(negedge clock) begin
        if (reset && w_valid) begin
            w_seen.push_back(w_data);
            w_seen_last.push_back(w_last);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        seen.delete();
        seen_last.delete();
        seen_t.delete();
    endtask

    initial begin
        longint t0;
        repeat (3) tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drops", 64'(drop_count), 64'd0);
        chk("rst_cycle", 64'(cycle), 64'd0);
        reset = 1'b1;
        repeat (5) tick();
        arm = 1'b1;
        sample = 1'b1;
        probe = 64'h1122334455667788;
        tick();
        sample = 1'b0;
        repeat (10) tick();
        chk("single_first_valid", 64'(first_valid), 64'd7);
        chk("single_beats", 64'(seen.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("single_data", 64'(seen[i]), 64'(e1[i]));
            chk("single_last", 64'(seen_last[i]), 64'(i == 3));
        end

        clear_log();
        t0 = now;
        sample = 1'b1;
        for (int i = 0; i < 3; i++) begin
            probe = 64'hA0 + 64'(i);
            tick();
        end
        sample = 1'b0;
        repeat (16) tick();
        chk("b2b_beats", 64'(seen.size()), 64'd12);
        chk("b2b_contiguous", 64'(seen_t[11] - seen_t[0]), 64'd11);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_probe", 64'(seen[4*i]), 64'hA0 + 64'(i));
            chk("b2b_stamp", 64'(seen[4*i+2]), 64'(t0 + i));
        end

        clear_log();
        t0 = now;
        sample = 1'b1;
        probe = 64'hAAAABBBBCCCCDDDD;
        tick();
        sample = 1'b0;
        repeat (2) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", 64'(out_data), 64'hAAAABBBB);
        end
        out_ready = 1'b1;
        repeat (6) tick();
        chk("bp_beats", 64'(seen.size()), 64'd4);
        chk("bp_beat0", 64'(seen[0]), 64'hCCCCDDDD);
        chk("bp_beat1", 64'(seen[1]), 64'hAAAABBBB);
        chk("bp_beat2", 64'(seen[2]), 64'(t0[31:0]));

        clear_log();
        out_ready = 1'b0;
        t0 = now;
        sample = 1'b1;
        for (int i = 0; i < 20; i++) begin
            probe = 64'(i);
            tick();
        end
        sample = 1'b0;
        tick();
        chk("ovf_drops", 64'(drop_count), 64'd3);
        chk("ovf_flag", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        repeat (80) tick();
        chk("ovf_beats", 64'(seen.size()), 64'd68);
        for (int k = 0; k < 17; k++) begin
            chk("ovf_order", 64'(seen[4*k]), 64'(k));
            chk("ovf_stamp", 64'(seen[4*k+2]), 64'(t0 + k));
        end

        sample = 1'b1;
        probe = 64'h0F0F0F0F12345678;
        tick();
        sample = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_last", 64'(out_last), 64'd0);
        chk("mid_rst_drops", 64'(drop_count), 64'd0);
        chk("mid_rst_overflow", 64'(overflow), 64'd0);
        chk("mid_rst_cycle", 64'(cycle), 64'd0);
        reset = 1'b1;
        clear_log();
        arm = 1'b0;
        sample = 1'b1;
        repeat (3) tick();
        repeat (3) tick();
        chk("disarmed_beats", 64'(seen.size()), 64'd0);
        arm = 1'b1;
        tick();
        sample = 1'b0;
        repeat (8) tick();
        chk("post_rst_beats", 64'(seen.size()), 64'd4);
        chk("post_rst_beat0", 64'(seen[0]), 64'h12345678);
        chk("post_rst_last2", 64'(seen_last[2]), 64'd0);
        chk("post_rst_last3", 64'(seen_last[3]), 64'd1);
        arm = 1'b0;

        reset = 1'b0;
        tick();
        reset = 1'b1;
        w_seen.delete();
        w_seen_last.delete();
        w_arm = 1'b1;
        repeat (255) tick();
        chk("wrap_cycle", 64'(w_cycle), 64'hFF);
        w_sample = 1'b1;
        w_probe = 64'h0123456789ABCDEF;
        tick();
        w_probe = 64'hFEDCBA9876543210;
        tick();
        w_sample = 1'b0;
        repeat (10) tick();
        chk("wrap_beats", 64'(w_seen.size()), 64'd6);
        chk("wrap_probe0", 64'(w_seen[0]), 64'h89ABCDEF);
        chk("wrap_stamp0", 64'(w_seen[2]), 64'hFF);
        chk("wrap_last0", 64'(w_seen_last[2]), 64'd1);
        chk("wrap_probe1", 64'(w_seen[3]), 64'h76543210);
        chk("wrap_stamp1", 64'(w_seen[5]), 64'h00);
        chk("wrap_ovf", 64'(w_ovf), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/sig_trace_recorder.md
Name: sig_trace_recorder

Overview:
- Capture-side counterpart of the signal replay flow: records a probe vector plus cycle stamp on each sampled cycle.
- Buffers records in a FIFO and serializes them into fixed-width beats over a valid/ready stream to the host, which writes the replay trace.
- Sits beside the target design in the simulation/FPGA wrapper; loss under backpressure is counted, never silent.

Parameters:
- PROBE_W, 64, width of captured probe vector.
- CYCLE_W, 48, width of free-running cycle stamp.
- BEAT_W, 32, output beat width.
- DEPTH, 16, record FIFO depth (power of two, >=2).
- CNT_W, 32, width of drop counter.

Ports:
- clock  in  1  clock.
- reset  in  1  reset; synchronous, active-low.
- arm  in  1  capture enable; samples ignored while low.
- sample  in  1  capture strobe for this cycle.
- probe  in  PROBE_W  signals to record.
- out_valid  out  1  beat valid.
- out_ready  in  1  host accepts beat.
- out_data  out  BEAT_W  current beat.
- out_last  out  1  final beat of a record.
- overflow  out  1  sticky: at least one record dropped.
- drop_count  out  CNT_W  dropped records, saturating.
- cycle  out  CYCLE_W  current cycle stamp.

Behaviour:
- Reset (reset==0 at posedge): cycle=0, FIFO empty, FSM IDLE, out_valid=0, out_data=0, out_last=0, overflow=0, drop_count=0. Partially sent record discarded.
- Cycle counter: +1 every clock while reset==1; wraps 2^CYCLE_W-1 -> 0, no flag.
- Record: REC = {cycle, probe}, probe in LSBs. NBEATS = ceil((PROBE_W+CYCLE_W)/BEAT_W); upper pad bits zero. Defaults: 4 beats = probe[31:0], probe[63:32], cycle[31:0], {16'b0, cycle[47:32]}.
- Capture: arm&&sample in cycle N pushes REC with the cycle value of cycle N.
- Full: if FIFO full in cycle N and no pop that cycle, record dropped; drop_count+1 (holds at all-ones), overflow set until reset. A pop and push in the same cycle on a full FIFO is accepted, no drop.
- FSM IDLE: if FIFO non-empty, pop head into shift register, beat_idx=0 -> SEND.
- FSM SEND: out_valid=1; out_data = shift_reg[BEAT_W-1:0]; out_last = (beat_idx==NBEATS-1).
  - Handshake (valid&&ready) on a non-last beat: shift right by BEAT_W, beat_idx+1.
  - Handshake on the last beat: if FIFO non-empty, reload from head in the same edge and stay in SEND (no bubble); else -> IDLE, out_valid=0.
- out_data/out_last stable while out_valid && !out_ready. The stream is never withdrawn.
- Latency: sample in cycle N with empty FIFO and IDLE -> out_valid high in N+2.
- Capacity: DEPTH records in FIFO + 1 in the shift register.
- arm low: stops capture only; queued records still drain.
- Record order preserved; beats never interleave between records.

Test Plan:
- Single capture (defaults): reset release, arm=1, sample=1 at cycle 5, probe=64'h1122334455667788 -> beats 55667788, 11223344, 00000005, 00000000; out_last on 4th; out_valid first seen cycle 7.
- Back-to-back: sample 3 consecutive cycles, out_ready=1 -> 12 beats contiguous, no idle cycle between records, stamps consecutive.
- Backpressure: out_ready=0 for 10 cycles mid-record -> out_data held constant; resumes with the next beat, no duplication.
- Overflow: out_ready=0, sample every cycle for 20 cycles -> 17 stored, drop_count=3, overflow=1; draining yields 17 records in order.
- Wrap: CYCLE_W=8, capture at cycles 255 and 256 -> stamps 0xFF then 0x00.
- Reset mid-record: assert reset after beat 1 accepted -> next cycle out_valid=0, drop_count=0, cycle=0; a new capture sends a full 4-beat record.
